// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream and register-write signals between the UART receiver, the
// command-frame controller and the register file it writes.
interface uart_cmd_ctrl_if;
  // i_rcv is a one-cycle strobe with no back-pressure: each cycle it is high,
  // i_data carries one byte that the controller must take on that edge.
  logic [7:0] i_data;
  logic       i_rcv;
  logic       i_clr_err;
  logic       o_wr;
  logic [7:0] o_addr;
  logic [7:0] o_wdata;
  logic       o_err;
  logic [7:0] o_err_cnt;
  logic       o_busy;
  logic [1:0] dbg_state;

  modport master (
    output i_data, i_rcv, i_clr_err,
    input  o_wr, o_addr, o_wdata, o_err, o_err_cnt, o_busy, dbg_state
  );

  modport slave (
    input  i_data, i_rcv, i_clr_err,
    output o_wr, o_addr, o_wdata, o_err, o_err_cnt, o_busy, dbg_state
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Parses sync/address/data/checksum frames from a UART byte stream into
// single-cycle register writes; flags and counts checksum errors and timeouts.
module uart_cmd_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 4096
) (
    input logic             clk,
    input logic             rstn,
    uart_cmd_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {SYNC, ADDR, DATA, CSUM} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] timer;
    logic [7:0]  addr_r;
    logic [7:0]  data_r;
    logic        csum_bad;
    logic        tmo;
    logic        err_now;

    assign csum_bad = (state == CSUM) && bus.i_rcv &&
                      (bus.i_data != (SYNC_BYTE ^ addr_r ^ data_r));
    // An arriving byte always beats the timeout on the same edge.
    assign tmo      = (state != SYNC) && !bus.i_rcv && (timer == TMO_LAST);
    assign err_now  = csum_bad || tmo;

    assign bus.o_busy    = (state != SYNC);
    assign bus.dbg_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= SYNC;
            timer         <= '0;
            addr_r        <= '0;
            data_r        <= '0;
            bus.o_wr      <= 1'b0;
            bus.o_addr    <= '0;
            bus.o_wdata   <= '0;
            bus.o_err     <= 1'b0;
            bus.o_err_cnt <= '0;
        end else begin
            bus.o_wr  <= 1'b0;
            bus.o_err <= err_now;

            if (bus.i_clr_err)
                bus.o_err_cnt <= '0;
            else if (err_now && bus.o_err_cnt != 8'hFF)
                bus.o_err_cnt <= bus.o_err_cnt + 8'd1;

            if (state == SYNC) begin
                timer <= '0;
                if (bus.i_rcv && bus.i_data == SYNC_BYTE)
                    state <= ADDR;
            end else if (bus.i_rcv) begin
                timer <= '0;
                case (state)
                    ADDR: begin
                        addr_r <= bus.i_data;
                        state  <= DATA;
                    end
                    DATA: begin
                        data_r <= bus.i_data;
                        state  <= CSUM;
                    end
                    default: begin
                        if (!csum_bad) begin
                            bus.o_wr    <= 1'b1;
                            bus.o_addr  <= addr_r;
                            bus.o_wdata <= data_r;
                        end
                        state <= SYNC;
                    end
                endcase
            end else if (tmo) begin
                timer <= '0;
                state <= SYNC;
            end else begin
                timer <= timer + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames plus randomized traffic, checked
// every cycle against a frame-buffer model and a set of literal expectations.
module tb_uart_cmd_ctrl;

    localparam int          TMO  = 16;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit clr_rand = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes of the partially received frame sit in a queue; a frame is
    // in progress exactly when the queue is non-empty.
    logic [7:0] frm[$];
    int         idle_cnt;
    bit         m_wr, m_err, e_now;
    logic [7:0] m_addr, m_wdata, m_cnt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frm.delete();
            idle_cnt = 0;
            m_wr = 0; m_err = 0;
            m_addr = 0; m_wdata = 0; m_cnt = 0;
        end else begin
            e_now = 0;
            m_wr  = 0;
            if (bus.i_rcv) begin
                idle_cnt = 0;
                if (frm.size() == 0) begin
                    if (bus.i_data == SYNC) frm.push_back(bus.i_data);
                end else if (frm.size() < 3) begin
                    frm.push_back(bus.i_data);
                end else begin
                    if ((frm[0] ^ frm[1] ^ frm[2]) == bus.i_data) begin
                        m_wr = 1; m_addr = frm[1]; m_wdata = frm[2];
                    end else begin
                        e_now = 1;
                    end
                    frm.delete();
                end
            end else if (frm.size() != 0) begin
                idle_cnt++;
                if (idle_cnt >= TMO) begin
                    e_now = 1;
                    frm.delete();
                    idle_cnt = 0;
                end
            end
            m_err = e_now;
            if (bus.i_clr_err) m_cnt = 0;
            else if (e_now && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr",      {7'd0, bus.o_wr},   {7'd0, m_wr});
            chk("err",     {7'd0, bus.o_err},  {7'd0, m_err});
            chk("addr",    bus.o_addr,         m_addr);
            chk("wdata",   bus.o_wdata,        m_wdata);
            chk("err_cnt", bus.o_err_cnt,      m_cnt);
            chk("busy",    {7'd0, bus.o_busy}, {7'd0, 1'(frm.size() != 0)});
            chk("dbg",     {7'd0, 1'(bus.dbg_state != 2'd0)}, {7'd0, 1'(frm.size() != 0)});
        end
    end

    // Both tasks start and end at a falling edge.
    task automatic strobe(input logic [7:0] b);
        bus.i_rcv = 1'b1;
        bus.i_data = b;
        bus.i_clr_err = clr_rand && ($urandom_range(0, 15) == 0);
        @(negedge clk);
        bus.i_rcv = 1'b0;
        bus.i_clr_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.i_clr_err = clr_rand && ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        bus.i_clr_err = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        strobe(SYNC); strobe(a); strobe(d); strobe(c);
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr",   {7'd0, bus.o_wr},   8'h00);
        chk("rst_err",  {7'd0, bus.o_err},  8'h00);
        chk("rst_busy", {7'd0, bus.o_busy}, 8'h00);
        chk("rst_addr", bus.o_addr,         8'h00);
        chk("rst_data", bus.o_wdata,        8'h00);
        chk("rst_cnt",  bus.o_err_cnt,      8'h00);
        #2 rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.i_data = 8'h00;
        bus.i_rcv = 1'b0;
        bus.i_clr_err = 1'b0;
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;

        // Spaced single-cycle strobes, valid checksum.
        strobe(SYNC); idle(12); strobe(8'h12); idle(12); strobe(8'h34); idle(12);
        strobe(8'h83);
        chk("lit_wr",    {7'd0, bus.o_wr}, 8'h01);
        chk("lit_addr",  bus.o_addr,       8'h12);
        chk("lit_wdata", bus.o_wdata,      8'h34);
        idle(1);
        chk("lit_wr_one", {7'd0, bus.o_wr}, 8'h00);
        chk("lit_cnt0",  bus.o_err_cnt,    8'h00);

        // Bad checksum holds the write outputs; then a good frame.
        frame(8'h12, 8'h34, 8'h00);
        chk("lit_cerr",  {7'd0, bus.o_err}, 8'h01);
        chk("lit_cerr_wr", {7'd0, bus.o_wr}, 8'h00);
        chk("lit_cnt1",  bus.o_err_cnt,    8'h01);
        chk("lit_hold",  bus.o_addr,       8'h12);
        frame(8'h01, 8'h02, 8'hA6);
        chk("lit_a01",   bus.o_addr,       8'h01);
        chk("lit_d02",   bus.o_wdata,      8'h02);

        // Noise ignored before sync; sync value as address/data is ordinary data.
        strobe(8'h00); strobe(8'hFF); strobe(8'h5A);
        chk("lit_noise", bus.o_err_cnt, 8'h01);
        frame(8'hAA, 8'h55, 8'h5A);
        chk("lit_aAA",   bus.o_addr,  8'hAA);
        chk("lit_d55",   bus.o_wdata, 8'h55);
        frame(8'hA5, 8'hA5, 8'hA5);
        chk("lit_aA5",   bus.o_addr,  8'hA5);
        chk("lit_wr_a5", {7'd0, bus.o_wr}, 8'h01);

        // Timeout fires after edge E+TMO; a byte at edge E+TMO is accepted.
        strobe(SYNC); strobe(8'h12); idle(TMO - 1);
        chk("lit_pre_tmo", {7'd0, bus.o_err}, 8'h00);
        idle(1);
        chk("lit_tmo",     {7'd0, bus.o_err},  8'h01);
        chk("lit_tmo_busy", {7'd0, bus.o_busy}, 8'h00);
        strobe(SYNC); strobe(8'h12); idle(TMO - 1); strobe(8'h34);
        chk("lit_late_ok", {7'd0, bus.o_err},  8'h00);
        chk("lit_late_busy", {7'd0, bus.o_busy}, 8'h01);
        strobe(8'h83);
        chk("lit_late_wr", {7'd0, bus.o_wr}, 8'h01);

        // Saturation, then clear on the same edge as an error.
        for (int i = 0; i < 260; i++) frame(8'h00, 8'h00, 8'h00);
        chk("lit_sat", bus.o_err_cnt, 8'hFF);
        frame(8'h00, 8'h00, 8'h00);
        chk("lit_sat_hold", bus.o_err_cnt, 8'hFF);
        strobe(SYNC); strobe(8'h00); strobe(8'h00);
        bus.i_rcv = 1'b1; bus.i_data = 8'h00; bus.i_clr_err = 1'b1;
        @(negedge clk);
        bus.i_rcv = 1'b0; bus.i_clr_err = 1'b0;
        chk("lit_clr_cnt", bus.o_err_cnt, 8'h00);
        chk("lit_clr_err", {7'd0, bus.o_err}, 8'h01);

        // Reset mid-frame, then a clean frame.
        strobe(SYNC); strobe(8'h12);
        do_reset();
        frame(8'h07, 8'h08, 8'hAA);
        chk("lit_a07", bus.o_addr,  8'h07);
        chk("lit_d08", bus.o_wdata, 8'h08);

        // Randomized traffic: gaps near the timeout, corrupted checksums,
        // stray bytes and random error-count clears.
        clr_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a, d, c;
            a = 8'($urandom);
            d = 8'($urandom);
            c = SYNC ^ a ^ d;
            if ($urandom_range(0, 3) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) strobe(8'($urandom));
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 7) == 0) idle($urandom_range(TMO - 3, TMO + 2));
                else idle($urandom_range(0, 3));
                strobe(k == 0 ? SYNC : (k == 1 ? a : (k == 2 ? d : c)));
            end
        end
        clr_rand = 1'b0;
        idle(TMO + 4);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
